memory_access: RTL and testbench
================================

Name: memory_access

Overview:
- Memory stage of the 64-bit, 32-register pipeline, directly upstream of write-back.
- Performs doubleword loads/stores against an internal data memory with configurable multi-cycle latency.
- Holds the MEM/WB pipeline register whose outputs drive the write-back stage: register number, loaded data, ALU result, MemToReg and RegWrite.
- Stalls upstream while an access is in flight.

Parameters:
- MEM_WORDS, 256, number of 64-bit data memory words (power of two, ≥2).
- MEM_LATENCY, 2, cycles a load/store occupies the stage (≥1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- InValid  in  1  instruction present on the inputs this cycle.
- ALUResult  in  64  effective address for memory ops; result for others.
- WriteData  in  64  store data.
- Reg  in  5  destination register.
- MemRead  in  1  load.
- MemWrite  in  1  store.
- MemToReg  in  1  write-back select, passed through.
- RegWrite  in  1  register write enable, passed through.
- Stall  out  1  combinational; upstream must hold all inputs stable while high.
- OutValid  out  1  MEM/WB register holds a real instruction.
- Results  out  64  registered ALUResult.
- loadedData  out  64  registered load data.
- Reg2WB  out  5  registered Reg.
- MemToRegOut  out  1  registered MemToReg.
- RegWriteOut  out  1  registered RegWrite, gated as below.
- AddrFault  out  1  registered; access was misaligned or out of range.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: all registered outputs 0, FSM to IDLE, latency counter 0. Memory contents are not cleared.
- Reset mid-access: the access is abandoned and no memory write occurs.
- Word index = ALUResult[log2(MEM_WORDS)+2:3].
- An access is "good" when ALUResult[2:0]==0 and ALUResult>>3 < MEM_WORDS.
- Non-memory instruction (InValid=1, MemRead=MemWrite=0):
  - Stall=0.
  - Captured at the next edge: OutValid=1, Results=ALUResult, loadedData=0, other fields passed through.
- Memory op, good address:
  - Presented in cycle 0. FSM goes IDLE→WAIT; counter counts MEM_LATENCY-1 cycles.
  - Stall is high in cycles 0..MEM_LATENCY-2 and low in cycle MEM_LATENCY-1.
  - At the end of cycle MEM_LATENCY-1: a store writes mem[index]=WriteData; a load captures mem[index] into loadedData; the MEM/WB register loads with OutValid=1; FSM returns to IDLE.
  - MEM_LATENCY=1: no WAIT state, Stall never asserts.
- While Stall=1, the MEM/WB register loads a bubble: OutValid=0 and RegWriteOut=0; other fields are don't-care but are held at 0.
- MemRead and MemWrite both set: treated as a store. loadedData=0.
- InValid=0: bubble loaded, Stall=0.
- Back-to-back memory ops: the next op is accepted in the cycle after completion. No idle cycle is inserted.
- Store followed by a load of the same address returns the new data.
- Store instructions: RegWriteOut follows the RegWrite input (the decoder clears it).
- Fault handling: see Optional Feature.

Optional Feature:
- Macro MEM_FAULT_CHECK_EN.
- Defined:
  - A memory op with a bad address completes in 1 cycle with Stall=0 and no memory write.
  - OutValid=1, AddrFault=1, loadedData=0, RegWriteOut=0.
  - AddrFault is 0 for all other captures.
- Undefined:
  - No check is made. Index bits are used directly (out-of-range wraps modulo MEM_WORDS; ALUResult[2:0] is ignored).
  - AddrFault is tied to 0.
  - Every memory op takes MEM_LATENCY cycles.

Test Plan:
- Reset then idle: hold reset 2 cycles, InValid=0 → all outputs 0, Stall=0. Assert reset during cycle 1 of a store to 0x10 → mem[2] unchanged.
- ALU op: InValid=1, ALUResult=0x1234, Reg=7, RegWrite=1, MemToReg=0 → next cycle OutValid=1, Results=0x1234, Reg2WB=7, RegWriteOut=1, Stall never high.
- Store then load, MEM_LATENCY=2:
  - Store WriteData=0xDEADBEEF_CAFEF00D to address 0x18 → Stall=1 for 1 cycle; OutValid=0 then 1.
  - Then load 0x18 with Reg=3, MemToReg=1 → loadedData=0xDEADBEEF_CAFEF00D two cycles after presentation.
- Latency sweep MEM_LATENCY=1 and 4: load → Stall high for exactly 0 and 3 cycles respectively, OutValid=1 one cycle after Stall drops.
- Back-to-back: store 0x5 to 0x0, immediately load 0x0 → load returns 0x5; OutValid pattern 0,1,0,1 at MEM_LATENCY=2.
- Faults (with MEM_FAULT_CHECK_EN): load from 0x0C → next cycle AddrFault=1, RegWriteOut=0, loadedData=0, no stall. Store to MEM_WORDS*8 → AddrFault=1, mem[0] unchanged. Without the macro, the same store writes mem[0].

Source files
------------

// File: rtl/memory_access.sv
// Memory stage: doubleword loads/stores against an internal data memory with MEM_LATENCY-cycle access,
// plus the MEM/WB pipeline register. Define MEM_FAULT_CHECK_EN to enable misaligned/out-of-range fault handling.
module memory_access #(
    parameter int MEM_WORDS   = 256,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        InValid,
    input  logic [63:0] ALUResult,
    input  logic [63:0] WriteData,
    input  logic [4:0]  Reg,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemToReg,
    input  logic        RegWrite,
    output logic        Stall,
    output logic        OutValid,
    output logic [63:0] Results,
    output logic [63:0] loadedData,
    output logic [4:0]  Reg2WB,
    output logic        MemToRegOut,
    output logic        RegWriteOut,
    output logic        AddrFault
);

    // state | meaning
    // IDLE  | accepting a new instruction; a memory op starts here (cycle 0)
    // WAIT  | memory op in flight; cnt counts down to the completing cycle
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam int IW = $clog2(MEM_WORDS);
    localparam int CW = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = (MEM_LATENCY > 1) ? CW'(MEM_LATENCY - 2) : '0;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [63:0]   mem [MEM_WORDS];

    logic          mem_op;
    logic          bad;
    logic          access;
    logic          done;
    logic          capture;
    logic          wr_en;
    logic          rd_en;
    logic [IW-1:0] idx;

    assign mem_op = MemRead | MemWrite;
    assign idx    = ALUResult[IW+2:3];

`ifdef MEM_FAULT_CHECK_EN
    logic good;
    assign good = (ALUResult[2:0] == 3'b000) && (ALUResult[63:IW+3] == '0);
    assign bad  = InValid & mem_op & ~good;
`else
    assign bad  = 1'b0;
`endif

    // Faulting ops bypass the access entirely and complete as a single-cycle capture.
    assign access = InValid & mem_op & ~bad;

    always_comb begin
        Stall = 1'b0;
        done  = 1'b0;
        if (state == ST_WAIT) begin
            Stall = (cnt != '0);
            done  = (cnt == '0);
        end else if (access) begin
            if (MEM_LATENCY == 1) begin
                done = 1'b1;
            end else begin
                Stall = 1'b1;
            end
        end
    end

    assign capture = ~reset & ~Stall & InValid;
    assign wr_en   = ~reset & done & MemWrite;
    assign rd_en   = done & MemRead & ~MemWrite;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (access && (MEM_LATENCY > 1)) begin
                        state <= ST_WAIT;
                        cnt   <= CNT_INIT;
                    end
                end
                default: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    // Data array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (!capture) begin
            OutValid    <= 1'b0;
            Results     <= '0;
            loadedData  <= '0;
            Reg2WB      <= '0;
            MemToRegOut <= 1'b0;
            RegWriteOut <= 1'b0;
        end else begin
            OutValid    <= 1'b1;
            Results     <= ALUResult;
            loadedData  <= rd_en ? mem[idx] : '0;
            Reg2WB      <= Reg;
            MemToRegOut <= MemToReg;
            RegWriteOut <= RegWrite & ~bad;
        end
    end

`ifdef MEM_FAULT_CHECK_EN
    always_ff @(posedge clk) begin
        AddrFault <= capture & bad;
    end
`else
    assign AddrFault = 1'b0;
`endif

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: one instance at MEM_LATENCY=2 plus latency-1 and latency-4 instances.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        reset;
    logic        iv_a, iv_b, iv_c;
    logic [63:0] alu, wd;
    logic [4:0]  rg;
    logic        mr, mw, m2r, rw;

    logic        a_stall, a_ov, a_m2r, a_rwo, a_af;
    logic [63:0] a_res, a_ld;
    logic [4:0]  a_reg;
    logic        b_stall, b_ov, b_m2r, b_rwo, b_af;
    logic [63:0] b_res, b_ld;
    logic [4:0]  b_reg;
    logic        c_stall, c_ov, c_m2r, c_rwo, c_af;
    logic [63:0] c_res, c_ld;
    logic [4:0]  c_reg;

    int          total = 0;
    int          bad   = 0;
    int          sel   = 0;
    int          n;
    logic [7:0]  ov_log;
    logic        cur_stall, cur_ov;

    always #5 clk = ~clk;

    memory_access #(.MEM_WORDS(256), .MEM_LATENCY(2)) dut (
        .clk(clk), .reset(reset), .InValid(iv_a), .ALUResult(alu), .WriteData(wd),
        .Reg(rg), .MemRead(mr), .MemWrite(mw), .MemToReg(m2r), .RegWrite(rw),
        .Stall(a_stall), .OutValid(a_ov), .Results(a_res), .loadedData(a_ld),
        .Reg2WB(a_reg), .MemToRegOut(a_m2r), .RegWriteOut(a_rwo), .AddrFault(a_af)
    );

    memory_access #(.MEM_WORDS(256), .MEM_LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset), .InValid(iv_b), .ALUResult(alu), .WriteData(wd),
        .Reg(rg), .MemRead(mr), .MemWrite(mw), .MemToReg(m2r), .RegWrite(rw),
        .Stall(b_stall), .OutValid(b_ov), .Results(b_res), .loadedData(b_ld),
        .Reg2WB(b_reg), .MemToRegOut(b_m2r), .RegWriteOut(b_rwo), .AddrFault(b_af)
    );

    memory_access #(.MEM_WORDS(256), .MEM_LATENCY(4)) dut_l4 (
        .clk(clk), .reset(reset), .InValid(iv_c), .ALUResult(alu), .WriteData(wd),
        .Reg(rg), .MemRead(mr), .MemWrite(mw), .MemToReg(m2r), .RegWrite(rw),
        .Stall(c_stall), .OutValid(c_ov), .Results(c_res), .loadedData(c_ld),
        .Reg2WB(c_reg), .MemToRegOut(c_m2r), .RegWriteOut(c_rwo), .AddrFault(c_af)
    );

    always_comb begin
        cur_stall = a_stall;
        cur_ov    = a_ov;
        case (sel)
            1: begin cur_stall = b_stall; cur_ov = b_ov; end
            2: begin cur_stall = c_stall; cur_ov = c_ov; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ov_log = {ov_log[6:0], cur_ov};
    endtask

    task automatic idle();
        iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0;
        mr = 1'b0; mw = 1'b0;
        tick();
    endtask

    // Presents one instruction to instance s and returns after its completing edge; counts stall cycles.
    task automatic op(input int s, input logic [63:0] a, input logic [63:0] d, input logic [4:0] r,
                      input logic mrd, input logic mwr, input logic mtr, input logic rwr,
                      output int stalls);
        sel = s;
        alu = a; wd = d; rg = r; mr = mrd; mw = mwr; m2r = mtr; rw = rwr;
        iv_a = (s == 0); iv_b = (s == 1); iv_c = (s == 2);
        stalls = 0;
        #4;
        while (cur_stall && stalls < 16) begin
            stalls++;
            tick();
            #3;
        end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0;
        alu = '0; wd = '0; rg = '0; mr = 1'b0; mw = 1'b0; m2r = 1'b0; rw = 1'b0;
        ov_log = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ov",    a_ov,    0);
        check("rst_res",   a_res,   0);
        check("rst_ld",    a_ld,    0);
        check("rst_reg",   a_reg,   0);
        check("rst_m2r",   a_m2r,   0);
        check("rst_rwo",   a_rwo,   0);
        check("rst_af",    a_af,    0);
        check("rst_stall", a_stall, 0);
        reset = 1'b0;
        tick();

        // store 0x1111 to 0x10, then abort a second store to 0x10 with reset
        op(0, 64'h10, 64'h1111, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, n);
        check("st1_stall", n, 1);
        alu = 64'h10; wd = 64'h2222; mw = 1'b1; mr = 1'b0; iv_a = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        iv_a = 1'b0; mw = 1'b0;
        check("rstmid_ov",  a_ov,  0);
        check("rstmid_res", a_res, 0);
        tick();
        op(0, 64'h10, 64'h0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1, n);
        check("rstmid_nowrite", a_ld, 64'h1111);

        // ALU op
        idle();
        op(0, 64'h1234, 64'h0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, n);
        check("alu_stall", n, 0);
        check("alu_ov",    a_ov, 1);
        check("alu_res",   a_res, 64'h1234);
        check("alu_reg",   a_reg, 7);
        check("alu_rwo",   a_rwo, 1);
        check("alu_m2r",   a_m2r, 0);
        check("alu_ld",    a_ld, 0);

        // store then load at 0x18
        idle();
        ov_log = '0;
        op(0, 64'h18, 64'hDEADBEEF_CAFEF00D, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, n);
        check("st_stall", n, 1);
        check("st_ovseq", ov_log[1:0], 2'b01);
        check("st_rwo",   a_rwo, 0);
        idle();
        op(0, 64'h18, 64'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, n);
        check("ld_stall", n, 1);
        check("ld_data",  a_ld, 64'hDEADBEEF_CAFEF00D);
        check("ld_reg",   a_reg, 3);
        check("ld_m2r",   a_m2r, 1);
        check("ld_rwo",   a_rwo, 1);
        check("ld_res",   a_res, 64'h18);

        // InValid=0 bubble
        idle();
        check("bub_ov",  a_ov, 0);
        check("bub_rwo", a_rwo, 0);
        check("bub_res", a_res, 0);

        // MemRead+MemWrite behaves as a store
        op(0, 64'h20, 64'h77, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, n);
        check("rw_stall", n, 1);
        check("rw_ld",    a_ld, 0);
        idle();
        op(0, 64'h20, 64'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, n);
        check("rw_readback", a_ld, 64'h77);
        idle();
        op(0, 64'h08, 64'hABCD, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, n);

        // back-to-back store/load at 0x0
        idle();
        ov_log = '0;
        op(0, 64'h0, 64'h5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, n);
        op(0, 64'h0, 64'h0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, n);
        check("b2b_ovseq", ov_log[3:0], 4'b0101);
        check("b2b_ld",    a_ld, 64'h5);

        // latency sweep
        idle();
        op(1, 64'h0, 64'h0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1, n);
        check("l1_stall", n, 0);
        check("l1_ov",    cur_ov, 1);
        idle();
        ov_log = '0;
        op(2, 64'h0, 64'h0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1, n);
        check("l4_stall", n, 3);
        check("l4_ovseq", ov_log[3:0], 4'b0001);
        idle();
        sel = 0;

        // misaligned load, out-of-range store, then read back mem[0]
        idle();
        op(0, 64'h0C, 64'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, n);
        check("flt_ld_ov", a_ov, 1);
`ifdef MEM_FAULT_CHECK_EN
        check("flt_ld_stall", n, 0);
        check("flt_ld_af",    a_af, 1);
        check("flt_ld_rwo",   a_rwo, 0);
        check("flt_ld_data",  a_ld, 0);
`else
        check("flt_ld_stall", n, 1);
        check("flt_ld_af",    a_af, 0);
        check("flt_ld_rwo",   a_rwo, 1);
        check("flt_ld_data",  a_ld, 64'hABCD);
`endif
        idle();
        op(0, 64'd2048, 64'h9999, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, n);
`ifdef MEM_FAULT_CHECK_EN
        check("flt_st_stall", n, 0);
        check("flt_st_af",    a_af, 1);
`else
        check("flt_st_stall", n, 1);
        check("flt_st_af",    a_af, 0);
`endif
        idle();
        op(0, 64'h0, 64'h0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1, n);
        check("flt_rb_af", a_af, 0);
`ifdef MEM_FAULT_CHECK_EN
        check("flt_rb_data", a_ld, 64'h5);
`else
        check("flt_rb_data", a_ld, 64'h9999);
`endif
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
